// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the op handshake, the accumulator/condition outputs and the
// alu-facing bus of alu_sequencer.
//   master : op issuer + external alu (drives op_*, alu_out and alu flags)
//   slave  : alu_sequencer itself (drives op_ready, acc, cond, done/err, alu_in*)
// Signals:
//   op_valid/op_ready/op_code/op_value   op handshake
//   acc, cond_plus, cond_minus           architectural state
//   done, err                            retire pulses
//   alu_in0, alu_in1, alu_funct          operands and function to the alu
//   alu_out, alu_overflow, alu_gr/le/eq  alu results
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int WIDTH = 11
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] op_value;
    logic [WIDTH-1:0] acc;
    logic             cond_plus;
    logic             cond_minus;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic [3:0]       alu_funct;
    logic [WIDTH-1:0] alu_out;
    logic             alu_overflow;
    logic             alu_gr;
    logic             alu_le;
    logic             alu_eq;

    modport master (
        output op_valid, op_code, op_value,
        output alu_out, alu_overflow, alu_gr, alu_le, alu_eq,
        input  op_ready, acc, cond_plus, cond_minus, done, err,
        input  alu_in0, alu_in1, alu_funct
    );

    modport slave (
        input  op_valid, op_code, op_value,
        input  alu_out, alu_overflow, alu_gr, alu_le, alu_eq,
        output op_ready, acc, cond_plus, cond_minus, done, err,
        output alu_in0, alu_in1, alu_funct
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Issuing side of the alu. Owns the signed accumulator and the +/- condition
// flags. Accepts one op per valid/ready handshake, presents acc and the
// clamped operand to the alu, then captures the alu result, saturating to
// +/-ACC_MAX, and resolves test ops into cond_plus/cond_minus.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      alu_sequencer_if.slave (op handshake, acc/cond, done/err, alu bus)
// Op codes: 0 MOV, 1 ADD, 2 SUB, 3 MUL, 4 NOT, 5 TEQ, 6 TGT, 7 TLT, 8 TCP,
//           9-15 illegal (retire with err).
// Sequence: IDLE -> ISSUE -> CAPTURE -> IDLE, one op every three cycles.
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH    = 11,
    parameter int ACC_MAX  = 999,
    parameter int NOT_TRUE = 100
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_sequencer_if.slave bus
);
    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_TEQ = 4'd5;
    localparam logic [3:0] OP_TGT = 4'd6;
    localparam logic [3:0] OP_TLT = 4'd7;
    localparam logic [3:0] OP_TCP = 4'd8;
    localparam int         NUM_OPS = 9;

    localparam logic [3:0] FN_ADD = 4'b1000;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_MUL = 4'b1010;
    localparam logic [3:0] FN_NOT = 4'b1011;

    localparam logic signed [WIDTH-1:0] ACC_POS  = WIDTH'(ACC_MAX);
    localparam logic signed [WIDTH-1:0] ACC_NEG  = WIDTH'(-ACC_MAX);
    localparam logic signed [WIDTH-1:0] NOT_VAL  = WIDTH'(NOT_TRUE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  acc_q, acc_d;
    logic                     cond_plus_q, cond_plus_d;
    logic                     cond_minus_q, cond_minus_d;
    logic        [WIDTH-1:0]  alu_in1_q, alu_in1_d;
    logic        [3:0]        alu_funct_q, alu_funct_d;
    logic        [3:0]        op_q, op_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    // One-hot decode of the latched op; any hit means the op is legal.
    logic [NUM_OPS-1:0]       op_hot;
    logic                     op_legal;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_dec
        assign op_hot[gi] = (op_q == 4'(gi));
    end
    assign op_legal = |op_hot;

    function automatic logic signed [WIDTH-1:0] clamp(input logic signed [WIDTH-1:0] x);
        if (x > ACC_POS) begin
            return ACC_POS;
        end else if (x < ACC_NEG) begin
            return ACC_NEG;
        end
        return x;
    endfunction

    // MOV never reaches the alu; tests only need the compare flags, and SUB
    // is used so the alu sees a defined function. Illegal ops fall back to ADD.
    function automatic logic [3:0] map_funct(input logic [3:0] code);
        case (code)
            OP_ADD:                         return FN_ADD;
            OP_SUB:                         return FN_SUB;
            OP_MUL:                         return FN_MUL;
            OP_NOT:                         return FN_NOT;
            OP_TEQ, OP_TGT, OP_TLT, OP_TCP: return FN_SUB;
            default:                        return FN_ADD;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cond_plus_d  = cond_plus_q;
        cond_minus_d = cond_minus_q;
        alu_in1_d    = alu_in1_q;
        alu_funct_d  = alu_funct_q;
        op_d         = op_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    alu_in1_d   = clamp($signed(bus.op_value));
                    alu_funct_d = map_funct(bus.op_code);
                    op_d        = bus.op_code;
                    state_d     = ST_ISSUE;
                end
            end

            // alu inputs are held for a whole cycle so its output can settle.
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = ~op_legal;
                case (op_q)
                    OP_MOV: begin
                        acc_d = $signed(alu_in1_q);
                    end
                    OP_ADD, OP_SUB: begin
                        // A wrapped sum has the opposite sign of the true result.
                        if (bus.alu_overflow) begin
                            acc_d = bus.alu_out[WIDTH-1] ? ACC_POS : ACC_NEG;
                        end else begin
                            acc_d = clamp($signed(bus.alu_out));
                        end
                    end
                    OP_MUL: begin
                        // Product sign follows the operand signs, not the wrapped bits.
                        if (bus.alu_overflow) begin
                            acc_d = (acc_q[WIDTH-1] ^ alu_in1_q[WIDTH-1]) ? ACC_NEG : ACC_POS;
                        end else begin
                            acc_d = clamp($signed(bus.alu_out));
                        end
                    end
                    OP_NOT: begin
                        acc_d = (bus.alu_out != '0) ? NOT_VAL : '0;
                    end
                    OP_TEQ: begin
                        cond_plus_d  = bus.alu_eq;
                        cond_minus_d = ~bus.alu_eq;
                    end
                    OP_TGT: begin
                        cond_plus_d  = bus.alu_gr;
                        cond_minus_d = ~bus.alu_gr;
                    end
                    OP_TLT: begin
                        cond_plus_d  = bus.alu_le;
                        cond_minus_d = ~bus.alu_le;
                    end
                    OP_TCP: begin
                        cond_plus_d  = bus.alu_gr;
                        cond_minus_d = bus.alu_le;
                    end
                    default: begin
                        // illegal: architectural state untouched
                    end
                endcase
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cond_plus_q  <= 1'b0;
            cond_minus_q <= 1'b0;
            alu_in1_q    <= '0;
            alu_funct_q  <= FN_ADD;
            op_q         <= OP_MOV;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cond_plus_q  <= cond_plus_d;
            cond_minus_q <= cond_minus_d;
            alu_in1_q    <= alu_in1_d;
            alu_funct_q  <= alu_funct_d;
            op_q         <= op_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.op_ready   = (state_q == ST_IDLE);
    assign bus.acc        = acc_q;
    assign bus.cond_plus  = cond_plus_q;
    assign bus.cond_minus = cond_minus_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.alu_in0    = acc_q;
    assign bus.alu_in1    = alu_in1_q;
    assign bus.alu_funct  = alu_funct_q;
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    logic clk;
    logic reset_n;
    int   n_total;
    int   n_bad;

    alu_sequencer_if #(.WIDTH(11)) bus ();

    alu_sequencer #(.WIDTH(11), .ACC_MAX(999), .NOT_TRUE(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 11-bit signed alu: wraps the result, flags overflow for
    // ADD/SUB/MUL, NOT yields 127 for a zero input and 0 otherwise.
    int alu_a, alu_b, alu_r;
    always_comb begin
        alu_a = int'($signed(bus.alu_in0));
        alu_b = int'($signed(bus.alu_in1));
        alu_r = 0;
        case (bus.alu_funct)
            4'b1000: alu_r = alu_a + alu_b;
            4'b1001: alu_r = alu_a - alu_b;
            4'b1010: alu_r = alu_a * alu_b;
            4'b1011: alu_r = (alu_a == 0) ? 127 : 0;
            default: alu_r = 0;
        endcase
        bus.alu_out      = alu_r[10:0];
        bus.alu_overflow = (bus.alu_funct != 4'b1011) && (alu_r > 1023 || alu_r < -1024);
        bus.alu_gr       = alu_a > alu_b;
        bus.alu_le       = alu_a < alu_b;
        bus.alu_eq       = alu_a == alu_b;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic int acc_val();
        return int'($signed(bus.acc));
    endfunction

    // Issues one op from IDLE and checks issue-side registers, latency,
    // retire pulses and resulting architectural state.
    task automatic do_op(input string tag, input logic [3:0] code, input int val,
                         input int exp_funct, input int exp_in1, input int exp_acc,
                         input int exp_cp, input int exp_cm, input int exp_err);
        int lat;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_value = 11'(val);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk({tag, ".funct"}, int'(bus.alu_funct), exp_funct);
        chk({tag, ".in1"}, int'($signed(bus.alu_in1)), exp_in1);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, lat, 2);
        chk({tag, ".err"}, int'(bus.err), exp_err);
        chk({tag, ".acc"}, acc_val(), exp_acc);
        chk({tag, ".cp"}, int'(bus.cond_plus), exp_cp);
        chk({tag, ".cm"}, int'(bus.cond_minus), exp_cm);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, int'(bus.done | bus.err), 0);
        $display("op %s code=%0d val=%0d acc=%0d cond=%0d%0d err=%0d",
                 tag, code, val, acc_val(), bus.cond_plus, bus.cond_minus, bus.err);
    endtask

    initial begin
        int n_acc, n_done, d0, d1, seen;
        n_total      = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 4'd0;
        bus.op_value = 11'd0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst.acc", acc_val(), 0);
        chk("rst.cond", int'({bus.cond_plus, bus.cond_minus}), 0);
        chk("rst.ready", int'(bus.op_ready), 1);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.funct", int'(bus.alu_funct), 8);
        chk("rst.in1", int'(bus.alu_in1), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Saturation on add/sub overflow and operand clamping
        do_op("mov500",  4'd0,   500,  8,  500,   500, 0, 0, 0);
        do_op("add600",  4'd1,   600,  8,  600,   999, 0, 0, 0);
        do_op("sub1000", 4'd2,  1000,  9,  999,     0, 0, 0, 0);
        do_op("movm1000",4'd0, -1000,  8, -999,  -999, 0, 0, 0);

        // Multiply with and without overflow
        do_op("movm40",  4'd0,   -40,  8,  -40,   -40, 0, 0, 0);
        do_op("mul30a",  4'd3,    30, 10,   30,  -999, 0, 0, 0);
        do_op("mov20",   4'd0,    20,  8,   20,    20, 0, 0, 0);
        do_op("mul30b",  4'd3,    30, 10,   30,   600, 0, 0, 0);
        do_op("mov40",   4'd0,    40,  8,   40,    40, 0, 0, 0);
        do_op("mul30c",  4'd3,    30, 10,   30,   999, 0, 0, 0);

        // Logical NOT
        do_op("mov0",    4'd0,     0,  8,    0,     0, 0, 0, 0);
        do_op("not1",    4'd4,     0, 11,    0,   100, 0, 0, 0);
        do_op("not2",    4'd4,     0, 11,    0,     0, 0, 0, 0);

        // Tests against acc=5
        do_op("mov5",    4'd0,     5,  8,    5,     5, 0, 0, 0);
        do_op("tcp5",    4'd8,     5,  9,    5,     5, 0, 0, 0);
        do_op("tgt3",    4'd6,     3,  9,    3,     5, 1, 0, 0);
        do_op("tlt3",    4'd7,     3,  9,    3,     5, 0, 1, 0);
        do_op("teq5",    4'd5,     5,  9,    5,     5, 1, 0, 0);
        do_op("tcpm7",   4'd8,    -7,  9,   -7,     5, 1, 0, 0);
        do_op("mov0b",   4'd0,     0,  8,    0,     0, 1, 0, 0);

        // op_valid held for six cycles: exactly two accepts
        n_acc  = 0;
        n_done = 0;
        d0     = -1;
        d1     = -1;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = 4'd1;
        bus.op_value = 11'd1;
        for (int i = 0; i < 6; i++) begin
            if (bus.op_ready) n_acc++;
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (n_done == 0) d0 = i; else d1 = i;
                n_done++;
            end
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        chk("hold.accepts", n_acc, 2);
        chk("hold.dones", n_done, 2);
        chk("hold.done0", d0, 2);
        chk("hold.done1", d1, 5);
        chk("hold.acc", acc_val(), 2);
        $display("hold accepts=%0d dones=%0d acc=%0d", n_acc, n_done, acc_val());

        // Illegal op code
        do_op("ill12",   4'd12,   33,  8,   33,     2, 1, 0, 1);

        // Reset while ADD 7 is in ISSUE
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = 4'd1;
        bus.op_value = 11'd7;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        chk("midrst.busy", int'(bus.op_ready), 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        seen = int'(bus.done | bus.err);
        chk("midrst.acc", acc_val(), 0);
        chk("midrst.ready", int'(bus.op_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            seen = seen | int'(bus.done | bus.err);
        end
        chk("midrst.nodone", seen, 0);
        chk("midrst.acc2", acc_val(), 0);
        $display("midrst acc=%0d seen_done=%0d", acc_val(), seen);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
